// File: rtl/div_pkg.sv
// div_pkg: shared FSM encoding and sizing helpers for the non-restoring divider.
package div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  localparam int QMAX_W = 64;
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction
  function automatic logic [QMAX_W-1:0] dbz_q(input int w);
    return {QMAX_W{1'b1}} >> (QMAX_W - w);
  endfunction
endpackage

// File: rtl/div_nr_if.sv
// div_nr_if: operand/result handshakes of div_nr; signed_i exists only with DIV_SIGNED_EN.
interface div_nr_if #(parameter int A_DW = 16, parameter int B_DW = 8);
  logic            valid_i, ready_o, valid_o, ready_i, dbz_o;
  logic [A_DW-1:0] a_i, q_o;
  logic [B_DW-1:0] b_i, r_o;
`ifdef DIV_SIGNED_EN
  logic            signed_i;
`endif
  modport slave (
    input valid_i, a_i, b_i, ready_i,
`ifdef DIV_SIGNED_EN
    input signed_i,
`endif
    output ready_o, valid_o, q_o, r_o, dbz_o
  );
  modport master (
    output valid_i, a_i, b_i, ready_i,
`ifdef DIV_SIGNED_EN
    output signed_i,
`endif
    input ready_o, valid_o, q_o, r_o, dbz_o
  );
endinterface

// File: rtl/cla.sv
// cla: W-bit carry-lookahead adder built from generate/propagate terms.
module cla #(parameter int W = 9) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_c,
  output logic [W-1:0] o_s
);
  logic [W-1:0] w_g, w_p, w_c;
  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;
  always_comb begin
    w_c[0] = i_c;
    for (int k = 0; k < W - 1; k++) w_c[k+1] = w_g[k] | (w_p[k] & w_c[k]);
  end
  assign o_s = w_p ^ w_c;
endmodule

// File: rtl/div_step.sv
// div_step: one non-restoring iteration on a (B_DW+1)-bit signed partial remainder.
module div_step #(parameter int B_DW = 8) (
  input  logic [B_DW:0]   i_p,
  input  logic [B_DW-1:0] i_d,
  input  logic            i_bit,
  output logic [B_DW:0]   o_p,
  output logic            o_q
);
  logic [B_DW:0] w_sh, w_op;
  assign w_sh = {i_p[B_DW-1:0], i_bit};
  // intermediate shift may wrap; the add/sub result always fits back in range
  assign w_op = i_p[B_DW] ? {1'b0, i_d} : ~{1'b0, i_d};
  cla #(.W(B_DW + 1)) u_cla (.i_a(w_sh), .i_b(w_op), .i_c(~i_p[B_DW]), .o_s(o_p));
  assign o_q = ~o_p[B_DW];
endmodule

// File: rtl/div_nr.sv
// div_nr: sequential radix-2 non-restoring divider, one quotient bit per cycle.
// DIV_SIGNED_EN adds signed_i and two's-complement sign fixup in FIX.
module div_nr import div_pkg::*; #(
  parameter int A_DW = 16,
  parameter int B_DW = 8
) (
  input logic       clk_i,
  input logic       rst_i,
  div_nr_if.slave   bus
);
  localparam int CW = cnt_w(A_DW);
  localparam logic [A_DW-1:0] DBZ_Q = A_DW'(dbz_q(A_DW));
  state_t          r_state, w_nxt;
  logic            r_ready, r_dbz;
  logic [CW-1:0]   r_cnt;
  logic [A_DW-1:0] r_q, w_amag, w_qf;
  logic [B_DW:0]   r_p, w_p, w_rem, w_rf;
  logic [B_DW-1:0] r_d, w_bmag;
  logic            w_qb, w_acc, w_zero, w_sa, w_sb;
`ifdef DIV_SIGNED_EN
  logic            r_nq, r_nr;
  assign w_sa = bus.signed_i & bus.a_i[A_DW-1];
  assign w_sb = bus.signed_i & bus.b_i[B_DW-1];
  assign w_qf = r_nq ? -r_q : r_q;
  assign w_rf = r_nr ? -w_rem : w_rem;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_nq <= 1'b0;
      r_nr <= 1'b0;
    end else if (w_acc) begin
      r_nq <= w_sa ^ w_sb;
      r_nr <= w_sa;
    end
  end
`else
  assign w_sa = 1'b0;
  assign w_sb = 1'b0;
  assign w_qf = r_q;
  assign w_rf = w_rem;
`endif
  assign w_amag = w_sa ? -bus.a_i : bus.a_i;
  assign w_bmag = w_sb ? -bus.b_i : bus.b_i;
  assign w_acc  = r_ready & bus.valid_i;
  assign w_zero = bus.b_i == '0;
  assign w_rem  = r_p[B_DW] ? r_p + {1'b0, r_d} : r_p;
  always_comb begin
    w_nxt = (r_state == IDLE) ? (w_acc ? (w_zero ? DONE : CALC) : IDLE) :
            (r_state == CALC) ? ((r_cnt == '0) ? FIX : CALC) :
            (r_state == FIX)  ? DONE :
            (bus.ready_i ? IDLE : DONE);
  end
  div_step #(.B_DW(B_DW)) u_step (
    .i_p(r_p), .i_d(r_d), .i_bit(r_q[A_DW-1]), .o_p(w_p), .o_q(w_qb)
  );
  // r_q shifts dividend bits out of the top while quotient bits enter at the bottom
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
      r_dbz   <= 1'b0;
      r_cnt   <= '0;
      r_q     <= '0;
      r_p     <= '0;
      r_d     <= '0;
    end else begin
      r_state <= w_nxt;
      r_ready <= w_nxt == IDLE;
      if (w_acc) begin
        r_dbz <= w_zero;
        r_d   <= w_bmag;
        r_cnt <= CW'(A_DW - 1);
        r_q   <= w_zero ? DBZ_Q : w_amag;
        r_p   <= w_zero ? {1'b0, bus.a_i[B_DW-1:0]} : '0;
      end else if (r_state == CALC) begin
        r_p   <= w_p;
        r_q   <= {r_q[A_DW-2:0], w_qb};
        r_cnt <= r_cnt - 1'b1;
      end else if (r_state == FIX) begin
        r_q <= w_qf;
        r_p <= w_rf;
      end
    end
  end
  assign bus.ready_o = r_ready;
  assign bus.valid_o = r_state == DONE;
  assign bus.q_o     = r_q;
  assign bus.r_o     = r_p[B_DW-1:0];
  assign bus.dbz_o   = r_dbz;
endmodule

// File: tb/tb_div_nr.sv
// tb_div_nr: scoreboard bench for div_nr against an arithmetic reference model.
module tb_div_nr;
  localparam int A_DW = 16, B_DW = 8, N_RAND = 2500;
  typedef struct {
    logic [A_DW-1:0] q;
    logic [B_DW-1:0] r;
    logic            dbz;
    int              lat;
    int              acc;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, s_op = 1'b0, s_eff;
  always #5 clk = ~clk;
  div_nr_if #(.A_DW(A_DW), .B_DW(B_DW)) bus ();
  div_nr #(.A_DW(A_DW), .B_DW(B_DW)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
`ifdef DIV_SIGNED_EN
  assign bus.signed_i = s_op;
  assign s_eff = s_op;
`else
  assign s_eff = 1'b0;
`endif
  int cyc = 0, n_chk = 0, n_fail = 0, last_acc = -1, last_per = 0;
  bit b2b = 0, prev_v = 0;
  exp_t scb[$];
  exp_t e;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic exp_t model(logic [A_DW-1:0] a, logic [B_DW-1:0] b, logic s);
    exp_t x;
    int sa, sd;
    x.acc = 0;
    if (b == '0) begin
      x.q = '1; x.r = a[B_DW-1:0]; x.dbz = 1'b1; x.lat = 1;
    end else begin
      x.dbz = 1'b0; x.lat = A_DW + 2;
      if (s) begin
        sa = $signed(a); sd = $signed(b);
        x.q = A_DW'(sa / sd); x.r = B_DW'(sa % sd);
      end else begin
        x.q = A_DW'(a / b); x.r = B_DW'(a % b);
      end
    end
    return x;
  endfunction
  task automatic chk(string n, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", n, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (bus.valid_i && bus.ready_o) begin
      e = model(bus.a_i, bus.b_i, s_eff);
      e.acc = cyc;
      scb.push_back(e);
      if (b2b && last_acc >= 0) chk("accept spacing", cyc - last_acc, last_per);
      last_acc = cyc;
      last_per = e.dbz ? 2 : A_DW + 3;
    end
    if (bus.valid_o && !prev_v) begin
      chk("valid with pending op", scb.size() > 0, 1);
      if (scb.size() > 0) chk("latency", cyc - scb[0].acc, scb[0].lat);
    end
    if (bus.valid_o && bus.ready_i && scb.size() > 0) begin
      e = scb.pop_front();
      chk("q_o", bus.q_o, e.q);
      chk("r_o", bus.r_o, e.r);
      chk("dbz_o", bus.dbz_o, e.dbz);
    end
    prev_v = bus.valid_o;
  end
  task automatic send(logic [A_DW-1:0] a, logic [B_DW-1:0] b, logic s);
    bus.a_i = a; bus.b_i = b; s_op = s; bus.valid_i = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.ready_o) break;
    end
    chk("accept ready_o", bus.ready_o, 1);
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
  endtask
  task automatic wait_res(logic [A_DW-1:0] q, logic [B_DW-1:0] r, logic dbz);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus.valid_o) break;
    end
    chk("directed valid_o", bus.valid_o, 1);
    chk("directed q_o", bus.q_o, q);
    chk("directed r_o", bus.r_o, r);
    chk("directed dbz_o", bus.dbz_o, dbz);
    @(posedge clk); #1;
  endtask
  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [A_DW-1:0] ra;
    logic [B_DW-1:0] rb;
    logic rs;
    int sel, seen;
    bus.valid_i = 1'b0; bus.ready_i = 1'b1; bus.a_i = '0; bus.b_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ready_o", bus.ready_o, 0);
    chk("reset valid_o", bus.valid_o, 0);
    chk("reset q_o", bus.q_o, 0);
    chk("reset r_o", bus.r_o, 0);
    chk("reset dbz_o", bus.dbz_o, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("ready after reset", bus.ready_o, 1);
    @(posedge clk); #1;
    send(A_DW'(100), B_DW'(7), 1'b0);
    wait_res(A_DW'(14), B_DW'(2), 1'b0);
    send(A_DW'(16'h1234), '0, 1'b0);
    wait_res('1, B_DW'(8'h34), 1'b1);
`ifdef DIV_SIGNED_EN
    send(A_DW'(-100), B_DW'(7), 1'b1);
    wait_res(A_DW'(-14), B_DW'(-2), 1'b0);
    send({1'b1, {(A_DW-1){1'b0}}}, '1, 1'b1);
    wait_res({1'b1, {(A_DW-1){1'b0}}}, '0, 1'b0);
`endif
    bus.ready_i = 1'b0;
    send(A_DW'(1000), B_DW'(9), 1'b0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.valid_o) break;
    end
    chk("stall valid_o", bus.valid_o, 1);
    @(posedge clk); #1;
    bus.valid_i = 1'b1; bus.a_i = A_DW'(5); bus.b_i = B_DW'(1);
    repeat (10) begin
      @(negedge clk);
      chk("stall q_o", bus.q_o, 111);
      chk("stall r_o", bus.r_o, 1);
      chk("stall dbz_o", bus.dbz_o, 0);
      chk("stall valid_o held", bus.valid_o, 1);
      chk("stall ready_o", bus.ready_o, 0);
    end
    @(posedge clk); #1;
    bus.valid_i = 1'b0; bus.ready_i = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("idle valid_o", bus.valid_o, 0);
    chk("idle ready_o", bus.ready_o, 1);
    @(posedge clk); #1;
    send(A_DW'(16'hABCD), B_DW'(3), 1'b0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    scb.delete();
    seen = 0;
    repeat (A_DW + 6) begin
      @(negedge clk);
      if (bus.valid_o) seen = 1;
    end
    chk("no result after reset", seen, 0);
    @(posedge clk); #1;
    send('1, B_DW'(1), 1'b0);
    wait_res('1, '0, 1'b0);
    last_acc = -1;
    b2b = 1;
    for (int i = 0; i < N_RAND; i++) begin
      sel = $urandom_range(0, 15);
      ra = A_DW'($urandom);
      rb = (sel == 0) ? '0 : (sel < 4) ? B_DW'($urandom_range(1, 3)) : B_DW'($urandom);
`ifdef DIV_SIGNED_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      send(ra, rb, rs);
    end
    b2b = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (scb.size() == 0) break;
    end
    chk("scoreboard drained", scb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
